fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_skid.sv | 30 +++
 rtl/fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Owns the fetch FSM encoding, the boot PC and the MIPS field positions.
package fetch_pkg;

    typedef logic [31:0] i32;
    typedef logic [5:0]  i6;
    typedef logic [4:0]  i5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA,
        S_HOLD
    } fetch_state_t;

    localparam i32 RESET_PC  = 32'hBFC0_0000;

    localparam int ICODE_LSB = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SA_LSB    = 6;
    localparam int ACODE_LSB = 0;

    function automatic i6 get_icode(input i32 instr);
        return instr[ICODE_LSB +: 6];
    endfunction

    function automatic i5 get_rs(input i32 instr);
        return instr[RS_LSB +: 5];
    endfunction

    function automatic i5 get_rt(input i32 instr);
        return instr[RT_LSB +: 5];
    endfunction

    function automatic i5 get_rd(input i32 instr);
        return instr[RD_LSB +: 5];
    endfunction

    function automatic i5 get_sa(input i32 instr);
        return instr[SA_LSB +: 5];
    endfunction

    function automatic i6 get_acode(input i32 instr);
        return instr[ACODE_LSB +: 6];
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-bus handshake between the fetch stage (master) and memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic ireq_valid;
    i32   ireq_addr;
    logic iresp_addr_ok;
    logic iresp_data_ok;
    i32   iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_addr_ok,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_addr_ok,
        output iresp_data_ok,
        output iresp_data
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that returned while decode was stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic unload,
    input  i32   load_pc,
    input  i32   load_instr,
    output logic valid,
    output i32   pc,
    output i32   instr
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time, owns the F/D register,
// and redirects the fetch PC on taken branches without losing the delay slot.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    fetch_if.master  ibus,
    input  logic     D_stall,
    input  logic     d_jump,
    input  i32       d_target,
    output logic     D_valid,
    output i32       D_pc,
    output i6        D_icode,
    output i6        D_acode,
    output i5        D_rs,
    output i5        D_rt,
    output i5        D_rd,
    output i5        D_sa,
    output i32       f_pc,
    output i32       pred_pc
);

    fetch_state_t state, state_next;

    i32   fpc, fpc_next;
    i32   req_pc;
    logic pending, pending_next;
    i32   pend_target, pend_target_next;
    i32   d_instr;

    logic consumed;
    logic d_free;
    logic addr_accept;
    logic data_arrive;
    logic d_load_resp;
    logic skid_load;
    logic skid_unload;
    i32   resp_pc;

    logic skid_valid;
    i32   skid_pc;
    i32   skid_instr;

    assign consumed    = D_valid && !D_stall;
    assign d_free      = !D_valid || consumed;
    assign addr_accept = (state == S_WAIT_ADDR) && ibus.iresp_addr_ok;

    assign ibus.ireq_valid = (state == S_WAIT_ADDR);
    assign ibus.ireq_addr  = fpc;

    // A same-cycle completion belongs to the address still on the bus.
    assign resp_pc = (state == S_WAIT_ADDR) ? fpc : req_pc;

    fetch_skid u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .load       (skid_load),
        .unload     (skid_unload),
        .load_pc    (resp_pc),
        .load_instr (ibus.iresp_data),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            fpc         <= RESET_PC;
            req_pc      <= '0;
            pending     <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            fpc         <= fpc_next;
            pending     <= pending_next;
            pend_target <= pend_target_next;
            if (addr_accept) begin
                req_pc <= fpc;
            end
        end
    end

    always_comb begin
        state_next  = state;
        data_arrive = 1'b0;
        d_load_resp = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;

        case (state)
            S_IDLE: begin
                if (!skid_valid) begin
                    state_next = S_WAIT_ADDR;
                end
            end
            S_WAIT_ADDR: begin
                if (ibus.iresp_addr_ok) begin
                    if (ibus.iresp_data_ok) begin
                        data_arrive = 1'b1;
                    end else begin
                        state_next = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (ibus.iresp_data_ok) begin
                    data_arrive = 1'b1;
                end
            end
            S_HOLD: begin
                if (consumed) begin
                    skid_unload = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (data_arrive) begin
            if (d_free) begin
                d_load_resp = 1'b1;
                state_next  = S_IDLE;
            end else begin
                skid_load  = 1'b1;
                state_next = S_HOLD;
            end
        end
    end

    // Redirect: if the slot is already past the bus, jump now; otherwise the
    // slot's own acceptance carries the target into fpc.
    always_comb begin
        fpc_next         = fpc;
        pending_next     = pending;
        pend_target_next = pend_target;

        if (addr_accept) begin
            fpc_next     = pending ? pend_target : fpc + 32'd4;
            pending_next = 1'b0;
        end

        if (consumed && d_jump) begin
            if (fpc == D_pc + 32'd8) begin
                fpc_next = d_target;
            end else if (fpc == D_pc + 32'd4) begin
                if (addr_accept) begin
                    fpc_next = d_target;
                end else begin
                    pending_next     = 1'b1;
                    pend_target_next = d_target;
                end
            end
        end
    end

    // A consumed instruction with nothing behind it leaves a bubble (sll $0,$0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            D_valid <= 1'b0;
            D_pc    <= '0;
            d_instr <= '0;
        end else if (d_load_resp) begin
            D_valid <= 1'b1;
            D_pc    <= resp_pc;
            d_instr <= ibus.iresp_data;
        end else if (skid_unload) begin
            D_valid <= 1'b1;
            D_pc    <= skid_pc;
            d_instr <= skid_instr;
        end else if (consumed) begin
            D_valid <= 1'b0;
            d_instr <= '0;
        end
    end

    assign D_icode = get_icode(d_instr);
    assign D_rs    = get_rs(d_instr);
    assign D_rt    = get_rt(d_instr);
    assign D_rd    = get_rd(d_instr);
    assign D_sa    = get_sa(d_instr);
    assign D_acode = get_acode(d_instr);

    assign f_pc    = D_pc + 32'd4;
    assign pred_pc = D_pc + 32'd8;

endmodule
